imem_loader: RTL

Program loader that fills the instruction memory before the core runs. It consumes a byte stream with a valid/ready handshake (UART or debug bridge side), parses a word-count header, packs little-endian bytes into 32-bit instructions, and drives a word-aligned write port into instruction memory. It is the write side of the instruction memory: the fetch path reads with byte address bits [19:2], and this block writes at those same addresses. `o_busy` holds the core in reset while a load is in progress.

---
 rtl/imem_loader_pkg.sv | 37 +++
 rtl/imem_byte_packer.sv | 57 +++++
 rtl/imem_loader.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module      : imem_pkg
//  Description : Shared types and constants for the instruction-memory
//                program loader (state encoding, stream framing sizes,
//                default memory geometry).
//                Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    // Stream framing: 4-byte little-endian word count, then 4 bytes per word
    localparam int IMEM_HDR_BYTES  = 4;
    localparam int IMEM_WORD_BYTES = 4;

    // Default memory geometry: 2^18 words, fetch uses byte address [19:2]
    localparam int IMEM_MEM_DEPTH  = 1 << 18;
    localparam int IMEM_IDX_W      = $clog2(IMEM_MEM_DEPTH);
    localparam int IMEM_ADDR_W     = 32;

    // Loader FSM encoding; CHECK only exists when the checksum is built in
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd4,
`endif
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } imem_ld_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_byte_packer.sv
// ============================================================================
//  Module      : imem_byte_packer
//  Description : Little-endian byte-to-word packer. A 2-bit byte counter
//                steers each pushed byte into its lane of a 32-bit register.
//                o_word is the word including the byte pushed this cycle, so
//                the consumer sees the complete value on the cycle o_full
//                is asserted. Shared by the header count and the data words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_byte_packer
    import imem_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_full
);

    localparam logic [1:0] LAST_LANE = 2'(IMEM_WORD_BYTES - 1);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [31:0] w_word;

    // Merge the incoming byte into its lane so the full word is visible now
    always_comb begin
        w_word = r_word;
        if (i_push) begin
            w_word[{r_cnt, 3'b000} +: 8] = i_byte;
        end
    end

    // Byte lane counter and pack register; the counter wraps after 4 bytes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_clear) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (i_push) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= w_word;
        end
    end

    assign o_word = w_word;
    assign o_full = i_push && (r_cnt == LAST_LANE);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction-memory program loader. Parses a word-count
//                header from a valid/ready byte stream, packs little-endian
//                bytes into 32-bit words and writes them word-aligned into
//                instruction memory. o_busy holds the core in reset while a
//                load is in progress.
//                Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing
//                XOR checksum byte over the payload).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::*;
#(
    parameter int                     DATA_WIDTH_LENGTH = 32,
    parameter int                     MEM_DEPTH_LENGTH  = IMEM_MEM_DEPTH,
    parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR         = 32'h0000_0000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic [7:0]                   i_byte,
    input  logic                         i_byte_valid,
    output logic                         o_byte_ready,
    output logic                         o_wr_en,
    output logic [IMEM_ADDR_W-1:0]       o_wr_addr,
    output logic [DATA_WIDTH_LENGTH-1:0] o_wr_data,
    input  logic                         i_wr_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int                     IDX_W   = $clog2(MEM_DEPTH_LENGTH);
    localparam logic [IDX_W-1:0]       IDX_ONE = IDX_W'(1);
    localparam logic [IMEM_ADDR_W-1:0] DEPTH_N = IMEM_ADDR_W'(MEM_DEPTH_LENGTH);

    imem_ld_state_t                 r_state;
    logic [IMEM_ADDR_W-1:0]         r_count;
    logic [IDX_W-1:0]               r_idx;
    logic                           r_wr_en;
    logic [IMEM_ADDR_W-1:0]         r_wr_addr;
    logic [DATA_WIDTH_LENGTH-1:0]   r_wr_data;
    logic                           r_done;
    logic                           r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]                     r_csum;
`endif

    logic                           w_byte_ready;
    logic                           w_busy;
    logic                           w_xfer;
    logic                           w_start_ok;
    logic                           w_pk_push;
    logic [31:0]                    w_pk_word;
    logic                           w_pk_full;
    logic [IMEM_ADDR_W-1:0]         w_idx_ext;
    logic [IMEM_ADDR_W-1:0]         w_word_addr;
    logic                           w_last_word;

    // Handshake and busy decode from the registered state
    always_comb begin
        w_byte_ready = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            ST_HDR, ST_DATA: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
            end
            ST_WRITE: begin
                w_busy       = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
            end
`endif
            default: begin
                w_byte_ready = 1'b0;
                w_busy       = 1'b0;
            end
        endcase
    end

    assign w_xfer      = i_byte_valid && w_byte_ready;
    assign w_start_ok  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                     (r_state == ST_ERR));
    assign w_pk_push   = w_xfer && ((r_state == ST_HDR) || (r_state == ST_DATA));
    assign w_idx_ext   = {{(IMEM_ADDR_W - IDX_W){1'b0}}, r_idx};
    assign w_word_addr = BASE_ADDR + {{(IMEM_ADDR_W - IDX_W - 2){1'b0}}, r_idx, 2'b00};
    assign w_last_word = (w_idx_ext + 32'd1) == r_count;

    imem_byte_packer u_packer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_start_ok),
        .i_push  (w_pk_push),
        .i_byte  (i_byte),
        .o_word  (w_pk_word),
        .o_full  (w_pk_full)
    );

    // Loader sequencer with registered write port and sticky status flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum    <= 8'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_start) begin
                        r_state <= ST_HDR;
                        r_count <= '0;
                        r_idx   <= '0;
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum  <= 8'd0;
`endif
                    end
                end
                ST_HDR: begin
                    if (w_pk_full) begin
                        r_count <= w_pk_word;
                        if (w_pk_word > DEPTH_N) begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end else if (w_pk_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ i_byte;
`endif
                        if (w_pk_full) begin
                            r_state   <= ST_WRITE;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_word_addr;
                            r_wr_data <= w_pk_word;
                        end
                    end
                end
                ST_WRITE: begin
                    // Address and data stay put until memory takes the word
                    if (i_wr_ready) begin
                        r_wr_en <= 1'b0;
                        r_idx   <= r_idx + IDX_ONE;
                        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state <= ST_CHECK;
`else
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    // Written words are kept even when the checksum fails
                    if (w_xfer) begin
                        if (i_byte == r_csum) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_byte_ready = w_byte_ready;
    assign o_busy       = w_busy;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule

`default_nettype wire
